// File: rtl/btn_ctrl_if.sv
// Bundle between the DB debouncer levels and the btn_ctrl control outputs.
// The master side drives the button levels. The slave side (btn_ctrl) drives the control values.
interface btn_ctrl_if #(
    parameter int POS_W = 10
);
    logic             HS;
    logic             VS;
    logic             DF_UART;
    logic             DF_VGA;
    logic             h_step;
    logic             v_step;
    logic [POS_W-1:0] h_pos;
    logic [POS_W-1:0] v_pos;
    logic [1:0]       uart_fmt;
    logic [1:0]       vga_fmt;
    logic             uart_fmt_chg;
    logic             vga_fmt_chg;

    modport master (
        output HS, VS, DF_UART, DF_VGA,
        input  h_step, v_step, h_pos, v_pos,
        input  uart_fmt, vga_fmt, uart_fmt_chg, vga_fmt_chg
    );

    modport slave (
        input  HS, VS, DF_UART, DF_VGA,
        output h_step, v_step, h_pos, v_pos,
        output uart_fmt, vga_fmt, uart_fmt_chg, vga_fmt_chg
    );
endinterface

// File: rtl/btn_ctrl.sv
// Turns debounced button levels into position steps with hold-to-repeat and cyclic format selects.
// Every output comes straight from a flop and is clocked by clk.

// One position channel: an edge gives a step, holding gives auto-repeat, and a step advances a wrapping counter.
module btn_ctrl_step_ch #(
    parameter int MAX           = 639,
    parameter int POS_W         = 10,
    parameter int HOLD_CYCLES   = 12500000,
    parameter int REPEAT_CYCLES = 2500000,
    parameter int CNT_W         = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_i,
    output logic             step_o,
    output logic [POS_W-1:0] pos_o
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [POS_W-1:0] POS_LAST    = POS_W'(MAX);
    localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             step_q, step_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             rise;

    assign rise = btn_i & ~prev_q;

    always_comb begin
        // NOTE: every _d gets its default before the case, so no path through this block can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    step_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!btn_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    step_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_REPEAT: begin
                // A release that arrives on the terminal count wins, and no step is made.
                if (!btn_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    step_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        if (step_d) begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
        end else begin
            pos_d = pos_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            // prev_q resets high, so a button held through reset release does not count as an edge.
            prev_q  <= 1'b1;
            step_q  <= 1'b0;
            pos_q   <= '0;
        end else begin
            // NOTE: use non-blocking updates so that every flop here samples values from before the edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= btn_i;
            step_q  <= step_d;
            pos_q   <= pos_d;
        end
    end

    assign step_o = step_q;
    assign pos_o  = pos_q;

    a_pos_range: assert property (@(posedge clk) disable iff (!rst_n) pos_q <= POS_LAST);
    a_step_single: assert property (@(posedge clk) disable iff (!rst_n) step_q |=> !step_q);
endmodule

// One format channel: each rising edge advances a wrapping selector and raises a one-cycle change pulse.
module btn_ctrl_fmt_ch #(
    parameter int FMT_NUM = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_i,
    output logic [1:0] fmt_o,
    output logic       chg_o
);
    localparam logic [1:0] FMT_LAST = 2'(FMT_NUM - 1);

    logic       prev_q;
    logic [1:0] fmt_q, fmt_d;
    logic       chg_q, chg_d;

    always_comb begin
        fmt_d = fmt_q;
        chg_d = 1'b0;
        if (btn_i && !prev_q) begin
            fmt_d = (fmt_q == FMT_LAST) ? 2'd0 : fmt_q + 2'd1;
            chg_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
            fmt_q  <= 2'd0;
            chg_q  <= 1'b0;
        end else begin
            prev_q <= btn_i;
            fmt_q  <= fmt_d;
            chg_q  <= chg_d;
        end
    end

    assign fmt_o = fmt_q;
    assign chg_o = chg_q;

    a_fmt_range: assert property (@(posedge clk) disable iff (!rst_n) fmt_q <= FMT_LAST);
endmodule

module btn_ctrl #(
    parameter int H_MAX         = 639,
    parameter int V_MAX         = 479,
    parameter int POS_W         = 10,
    parameter int HOLD_CYCLES   = 12500000,
    parameter int REPEAT_CYCLES = 2500000,
    parameter int CNT_W         = 24,
    parameter int FMT_NUM       = 4
) (
    input logic        clk,
    input logic        rst_n,
    btn_ctrl_if.slave  bus
);
    logic             h_step, v_step;
    logic [POS_W-1:0] h_pos, v_pos;
    logic [1:0]       uart_fmt, vga_fmt;
    logic             uart_fmt_chg, vga_fmt_chg;

    btn_ctrl_step_ch #(
        .MAX(H_MAX), .POS_W(POS_W), .HOLD_CYCLES(HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W)
    ) u_h_ch (
        .clk(clk), .rst_n(rst_n), .btn_i(bus.HS), .step_o(h_step), .pos_o(h_pos)
    );

    btn_ctrl_step_ch #(
        .MAX(V_MAX), .POS_W(POS_W), .HOLD_CYCLES(HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W)
    ) u_v_ch (
        .clk(clk), .rst_n(rst_n), .btn_i(bus.VS), .step_o(v_step), .pos_o(v_pos)
    );

    btn_ctrl_fmt_ch #(.FMT_NUM(FMT_NUM)) u_uart_fmt (
        .clk(clk), .rst_n(rst_n), .btn_i(bus.DF_UART), .fmt_o(uart_fmt), .chg_o(uart_fmt_chg)
    );

    btn_ctrl_fmt_ch #(.FMT_NUM(FMT_NUM)) u_vga_fmt (
        .clk(clk), .rst_n(rst_n), .btn_i(bus.DF_VGA), .fmt_o(vga_fmt), .chg_o(vga_fmt_chg)
    );

    assign bus.h_step       = h_step;
    assign bus.v_step       = v_step;
    assign bus.h_pos        = h_pos;
    assign bus.v_pos        = v_pos;
    assign bus.uart_fmt     = uart_fmt;
    assign bus.vga_fmt      = vga_fmt;
    assign bus.uart_fmt_chg = uart_fmt_chg;
    assign bus.vga_fmt_chg  = vga_fmt_chg;
endmodule

// File: tb/tb_btn_ctrl.sv
// Scoreboard bench for btn_ctrl: the stimulus queues the expected output snapshot and its cycle,
// and a negedge monitor pops and compares an entry each time any pulse output is high.
module tb_btn_ctrl;
    localparam int POS_W = 10;

    typedef struct {
        int          at;
        logic [27:0] vec;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    btn_ctrl_if #(.POS_W(POS_W)) bus ();

    btn_ctrl #(
        .H_MAX(3), .V_MAX(2), .POS_W(POS_W), .HOLD_CYCLES(8),
        .REPEAT_CYCLES(4), .CNT_W(24), .FMT_NUM(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int at, input bit hs, input bit vs, input bit uc, input bit vc,
                        input int hp, input int vp, input int uf, input int vf);
        exp_t e;
        e.at  = at;
        e.vec = {hs, vs, uc, vc, 10'(hp), 10'(vp), 2'(uf), 2'(vf)};
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [27:0] snap();
        return {bus.h_step, bus.v_step, bus.uart_fmt_chg, bus.vga_fmt_chg,
                bus.h_pos, bus.v_pos, bus.uart_fmt, bus.vga_fmt};
    endfunction

    // The monitor compares one queued snapshot and its cycle number for each cycle in which a pulse output is high.
    always @(negedge clk) begin
        if (bus.h_step || bus.v_step || bus.uart_fmt_chg || bus.vga_fmt_chg) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got %h expected no pulse (cycle %0d)", snap(), cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_cycle", 64'(cyc), 64'(e.at));
                check("pulse_outputs", 64'(snap()), 64'(e.vec));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.HS = 1'b0; bus.VS = 1'b0; bus.DF_UART = 1'b0; bus.DF_VGA = 1'b0;
        tick(3);
        check("reset_outputs", 64'(snap()), 64'd0);
        rst_n = 1'b1;
        tick(3);

        // A short press makes a single step, and h_pos goes from 0 to 1.
        bus.HS = 1'b1; push(cyc + 1, 1, 0, 0, 0, 1, 0, 0, 0);
        tick(3); bus.HS = 1'b0; tick(4);

        // Holding for 30 cycles gives steps at +1,+9,+13,+17,+21,+25,+29, and h_pos wraps after 3.
        bus.HS = 1'b1;
        push(cyc + 1,  1, 0, 0, 0, 2, 0, 0, 0);
        push(cyc + 9,  1, 0, 0, 0, 3, 0, 0, 0);
        push(cyc + 13, 1, 0, 0, 0, 0, 0, 0, 0);
        push(cyc + 17, 1, 0, 0, 0, 1, 0, 0, 0);
        push(cyc + 21, 1, 0, 0, 0, 2, 0, 0, 0);
        push(cyc + 25, 1, 0, 0, 0, 3, 0, 0, 0);
        push(cyc + 29, 1, 0, 0, 0, 0, 0, 0, 0);
        tick(30); bus.HS = 1'b0; tick(3);

        // A release on the HOLD terminal count gives no step, and the next press steps again.
        bus.HS = 1'b1; push(cyc + 1, 1, 0, 0, 0, 1, 0, 0, 0);
        tick(8); bus.HS = 1'b0; tick(4);
        bus.HS = 1'b1; push(cyc + 1, 1, 0, 0, 0, 2, 0, 0, 0);
        tick(2); bus.HS = 1'b0; tick(3);

        // Format cycling with FMT_NUM=3: 1,2,0,1, then a 40-cycle hold changes the format only once.
        for (int i = 0; i < 5; i++) begin
            int exp_uf [5] = '{1, 2, 0, 1, 2};
            bus.DF_UART = 1'b1; push(cyc + 1, 0, 0, 1, 0, 2, 0, exp_uf[i], 0);
            tick((i == 4) ? 40 : 5); bus.DF_UART = 1'b0; tick(3);
        end

        // Edges on all four buttons in the same cycle give all four pulses together.
        bus.HS = 1'b1; bus.VS = 1'b1; bus.DF_UART = 1'b1; bus.DF_VGA = 1'b1;
        push(cyc + 1, 1, 1, 1, 1, 3, 1, 0, 1);
        tick(2);
        bus.HS = 1'b0; bus.VS = 1'b0; bus.DF_UART = 1'b0; bus.DF_VGA = 1'b0;
        tick(3);

        // A vertical hold with V_MAX=2 goes 2, then 0, then 1.
        bus.VS = 1'b1;
        push(cyc + 1,  0, 1, 0, 0, 3, 2, 0, 1);
        push(cyc + 9,  0, 1, 0, 0, 3, 0, 0, 1);
        push(cyc + 13, 0, 1, 0, 0, 3, 1, 0, 1);
        tick(14); bus.VS = 1'b0; tick(3);

        // Assert reset in the middle of HOLD, then release it with HS still held.
        bus.HS = 1'b1; bus.DF_UART = 1'b1;
        push(cyc + 1, 1, 0, 1, 0, 0, 1, 1, 1);
        tick(2); bus.DF_UART = 1'b0; tick(2);
        check("sb_empty_pre_reset", 64'(sb_q.size()), 64'd0);
        #2 rst_n = 1'b0;
        #1 check("midcycle_reset_outputs", 64'(snap()), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        bus.HS = 1'b0; tick(2);
        bus.HS = 1'b1; push(cyc + 1, 1, 0, 0, 0, 1, 0, 0, 0);
        tick(2); bus.HS = 1'b0; tick(3);
        check("post_reset_state", 64'(snap()), 64'({4'b0000, 10'd1, 10'd0, 2'd0, 2'd0}));

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
